// File: rtl/audio_out_streamer.sv
// audio_out_streamer: FIFO-buffered, left-justified stereo serializer feeding a DAC (bclk/lrclk/sdata).
// Define AUDIO_OUT_SAT_EN to saturate samples to the signed DATA_W range through a registered write path.
module audio_out_streamer #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [31:0]            sample_in,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    input  logic                   clr_flags,
    output logic                   bclk,
    output logic                   lrclk,
    output logic                   sdata,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                wr_en, full, empty, ovf_set;
    logic [DATA_W-1:0]   wr_data, new_sample, shreg, frame;
    logic [DW-1:0]       div;
    logic [BW-1:0]       bitcnt;
    logic                wrap, fall, last, fetch, stop, pop, udf_set;

`ifdef AUDIO_OUT_SAT_EN
    logic                in_range, pend;
    logic [DATA_W-1:0]   sat, pend_data;
    assign in_range = (&sample_in[31:DATA_W-1]) || !(|sample_in[31:DATA_W-1]);
    assign sat = in_range ? sample_in[DATA_W-1:0] : {sample_in[31], {(DATA_W-1){~sample_in[31]}}};
    // The staged word already owns a slot, so it counts towards full at the strobe.
    assign full = ({1'b0, fifo_count} + {{(AW+1){1'b0}}, pend}) == {1'b0, FULL_CNT};
    assign wr_en = pend;
    assign wr_data = pend_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_data <= '0;
        end else begin
            pend      <= sample_valid && !full;
            pend_data <= sat;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^sample_in[31:DATA_W];
    assign full = fifo_count == FULL_CNT;
    assign wr_en = sample_valid && !full;
    assign wr_data = sample_in[DATA_W-1:0];
`endif

    assign empty = fifo_count == '0;
    assign sample_ready = !full;
    assign ovf_set = sample_valid && full;
    assign wrap = div == DIV_MAX;
    assign fall = state != IDLE && wrap && bclk;
    assign last = fall && bitcnt == BIT_MAX;
    assign new_sample = pop ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // fetch marks a frame start: leaving IDLE, or the RIGHT->LEFT boundary while enabled.
    always_comb begin
        state_n = state;
        fetch   = 1'b0;
        stop    = 1'b0;
        case (state)
            IDLE: begin
                state_n = en ? LEFT : IDLE;
                fetch   = en;
            end
            LEFT: state_n = last ? RIGHT : LEFT;
            default: begin
                state_n = last ? (en ? LEFT : IDLE) : RIGHT;
                fetch   = last && en;
                stop    = last && !en;
            end
        endcase
        pop     = fetch && !empty;
        udf_set = fetch && empty;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
            overflow   <= ovf_set || (overflow && !clr_flags);
            underflow  <= udf_set || (underflow && !clr_flags);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= '0;
            bitcnt <= '0;
            bclk   <= 1'b0;
            lrclk  <= 1'b0;
            sdata  <= 1'b0;
            shreg  <= '0;
            frame  <= '0;
        end else begin
            div <= (state == IDLE || wrap) ? '0 : div + 1'b1;
            if (state != IDLE && wrap)
                bclk <= !bclk;
            if (fetch) begin
                frame  <= new_sample;
                shreg  <= new_sample;
                sdata  <= new_sample[DATA_W-1];
                lrclk  <= 1'b0;
                bitcnt <= '0;
            end else if (stop) begin
                sdata  <= 1'b0;
                lrclk  <= 1'b0;
                bitcnt <= '0;
            end else if (last) begin
                shreg  <= frame;
                sdata  <= frame[DATA_W-1];
                lrclk  <= 1'b1;
                bitcnt <= '0;
            end else if (fall) begin
                shreg  <= shreg << 1;
                sdata  <= shreg[DATA_W-2];
                bitcnt <= bitcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_out_streamer.sv
// tb_audio_out_streamer: table vectors plus a word scoreboard fed at write time and drained by a serial monitor.
module tb_audio_out_streamer;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 16;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = 4 * DATA_W * CLK_DIV;

    logic                   clk = 1'b0, rst = 1'b1, en = 1'b0, sample_valid = 1'b0, clr_flags = 1'b0;
    logic [31:0]            sample_in = '0;
    logic                   sample_ready, bclk, lrclk, sdata, overflow, underflow;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0, passed = 0;
    int n_b, n_l1, n_l2;
    logic lr_q;
    logic [DATA_W-1:0] exp_q[$];

    typedef struct {
        logic [31:0]       din;
        logic [DATA_W-1:0] trunc;
        logic [DATA_W-1:0] sat;
    } vec_t;
    vec_t tbl[6];

    audio_out_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .clr_flags(clr_flags), .bclk(bclk), .lrclk(lrclk),
        .sdata(sdata), .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req)
            passed++;
        else
            $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Serial monitor: rebuilds each channel word on bclk rising edges.
    logic bclk_q = 1'b0, ch = 1'b0;
    logic [DATA_W-1:0] word = '0, held = '0;
    int nb = 0;
    always @(negedge clk) begin
        if (rst) begin
            nb = 0;
            bclk_q = 1'b0;
        end else begin
            if (bclk && !bclk_q) begin
                if (nb == 0)
                    ch = lrclk;
                word = {word[DATA_W-2:0], sdata};
                nb++;
                if (nb == DATA_W) begin
                    nb = 0;
                    if (!ch) begin
                        if (exp_q.size() != 0)
                            held = exp_q.pop_front();
                        else
                            held = '0;
                        check("left_word", 32'(word), 32'(held));
                    end else
                        check("right_word", 32'(word), 32'(held));
                end
            end
            bclk_q = bclk;
        end
    end

    task automatic write(input logic [31:0] d);
        @(negedge clk);
        sample_in = d;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic drain_and_stop(input string tag, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        en = 1'b0;
        repeat (FRAME) @(negedge clk);
        check({tag, "_idle_bclk"}, bclk, 0);
        check({tag, "_idle_lrclk"}, lrclk, 0);
        check({tag, "_idle_sdata"}, sdata, 0);
        check({tag, "_idle_count"}, fifo_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0001_2345, 16'h2345, 16'h7FFF};
        tbl[1] = '{32'hFFFF_8000, 16'h8000, 16'h8000};
        tbl[2] = '{32'hFFFE_0000, 16'h0000, 16'h8000};
        tbl[3] = '{32'h0000_7FFF, 16'h7FFF, 16'h7FFF};
        tbl[4] = '{32'h1234_FFFF, 16'hFFFF, 16'h7FFF};
        tbl[5] = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF};

        repeat (3) @(negedge clk);
        check("rst_bclk", bclk, 0);
        check("rst_lrclk", lrclk, 0);
        check("rst_sdata", sdata, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", sample_ready, 1);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        rst = 1'b0;

        // Single word, then an underflow frame of zeros
        write(32'h0000_A5C3);
        exp_q.push_back(16'hA5C3);
        @(negedge clk);
        check("t2_count", fifo_count, 1);
        en = 1'b1;
        n_b = 0; n_l1 = 0; n_l2 = 0; lr_q = 1'b0;
        for (int n = 1; n <= 2 * FRAME && n_l2 == 0; n++) begin
            @(negedge clk);
            if (n == 1)
                check("t2_pop_count", fifo_count, 0);
            if (bclk && n_b == 0)
                n_b = n;
            if (lrclk && !lr_q) begin
                if (n_l1 == 0)
                    n_l1 = n;
                else
                    n_l2 = n;
            end
            lr_q = lrclk;
        end
        check("t2_first_bclk", n_b, CLK_DIV + 1);
        check("t2_lr_half", n_l1, FRAME / 2 + 1);
        check("t2_frame_len", n_l2 - n_l1, FRAME);
        check("t2_underflow", underflow, 1);
        en = 1'b0;
        repeat (FRAME) @(negedge clk);
        check("t2_idle_bclk", bclk, 0);
        check("t2_idle_sdata", sdata, 0);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("t2_clr_underflow", underflow, 0);

        // Table of conversions
        for (int i = 0; i < 6; i++) begin
            write(tbl[i].din);
`ifdef AUDIO_OUT_SAT_EN
            exp_q.push_back(tbl[i].sat);
`else
            exp_q.push_back(tbl[i].trunc);
`endif
            @(negedge clk);
            check($sformatf("t3_count%0d", i), fifo_count, i + 1);
        end
        en = 1'b1;
        drain_and_stop("t3", 8 * FRAME);
        check("t3_underflow", underflow, 0);

        // Fill beyond DEPTH
        for (int i = 0; i < DEPTH + 1; i++) begin
            write(32'h0101 + 32'(i) * 32'h0707);
            if (i < DEPTH)
                exp_q.push_back(DATA_W'(32'h0101 + 32'(i) * 32'h0707));
        end
        @(negedge clk);
        check("t4_count", fifo_count, DEPTH);
        check("t4_ready", sample_ready, 0);
        check("t4_overflow", overflow, 1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("t4_clr_overflow", overflow, 0);
        sample_in = 32'h0000_DEAD;
        sample_valid = 1'b1;
        clr_flags = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        clr_flags = 1'b0;
        check("t4_set_beats_clr", overflow, 1);
        check("t4_count_held", fifo_count, DEPTH);
        en = 1'b1;
        drain_and_stop("t4", (DEPTH + 2) * FRAME);
        check("t4_underflow", underflow, 0);
        check("t4_ready_after", sample_ready, 1);

        // Push and pop together at frame start and at the next boundary
        for (int i = 0; i < 3; i++) begin
            write(32'h1100 + 32'(i));
            exp_q.push_back(DATA_W'(32'h1100 + 32'(i)));
        end
        @(negedge clk);
        check("t5_count_pre", fifo_count, 3);
        sample_in = 32'h0000_3333;
        sample_valid = 1'b1;
        en = 1'b1;
        exp_q.push_back(16'h3333);
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        check("t5_start_count", fifo_count, 3);
        repeat (FRAME - 2) @(negedge clk);
        sample_in = 32'h0000_4444;
        sample_valid = 1'b1;
        exp_q.push_back(16'h4444);
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        check("t5_boundary_count", fifo_count, 3);
        drain_and_stop("t5", 7 * FRAME);

        // Reset in the middle of a right channel
        write(32'h0000_FFFF);
        write(32'h0000_1234);
        exp_q.push_back(16'hFFFF);
        @(negedge clk);
        en = 1'b1;
        repeat (FRAME / 2 + 7) @(negedge clk);
        check("t6_pre_lrclk", lrclk, 1);
        check("t6_pre_sdata", sdata, 1);
        check("t6_pre_count", fifo_count, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_bclk", bclk, 0);
        check("t6_rst_lrclk", lrclk, 0);
        check("t6_rst_sdata", sdata, 0);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_ready", sample_ready, 1);
        exp_q.delete();
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_post_count", fifo_count, 0);
        check("t6_post_bclk", bclk, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
